// File: rtl/delay_cal_pkg.sv
// Shared types, constants and helpers for the delay-line tap calibrator.
package delay_cal_pkg;

    localparam int NUM_TAPS = 4;
    localparam int TAP_W    = 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DRAIN,
        NEXT,
        EVAL
    } cal_state_e;

    // Index of the lowest set bit of v; returns 0 when v is empty, so callers test |v first.
    function automatic logic [TAP_W-1:0] lowest_set(input logic [NUM_TAPS-1:0] v);
        logic [TAP_W-1:0] idx;
        idx = '0;
        for (int i = NUM_TAPS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = TAP_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer bringing a single asynchronous bit into the clk domain.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    // Shift the raw input through the flop chain; the last flop is the usable copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/delay_tap_calibrator.sv
// Calibration controller for a 4-tap delay line: probes each tap, measures the
// echo latency in clock cycles and leaves mux_sel on the shortest acceptable tap.
module delay_tap_calibrator
    import delay_cal_pkg::*;
#(
    parameter int LAT_W       = 8,
    parameter int MAX_WAIT    = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LAT_W-1:0]          target,
    input  logic                      echo,
    output logic                      probe,
    output logic [TAP_W-1:0]          mux_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [NUM_TAPS*LAT_W-1:0] tap_lat
);

    localparam logic [LAT_W-1:0] MAX_CNT  = LAT_W'(MAX_WAIT);
    localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    cal_state_e          state_reg, state_next;
    logic [LAT_W-1:0]    cnt_reg, cnt_next;
    logic [LAT_W-1:0]    target_reg, target_next;
    logic [LAT_W-1:0]    tap_lat_reg  [NUM_TAPS];
    logic [LAT_W-1:0]    tap_lat_next [NUM_TAPS];
    logic [NUM_TAPS-1:0] timeout_reg, timeout_next;
    logic [TAP_W-1:0]    mux_sel_reg, mux_sel_next;
    logic                probe_reg, probe_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                fail_reg, fail_next;

    logic                echo_s;
    logic                echo_s_q_reg;
    logic                echo_rise;
    logic [NUM_TAPS-1:0] qualify;
    logic [LAT_W-1:0]    cnt_sat_inc;
    logic                cnt_last;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_echo_sync (
        .clk  (clk),
        .reset(reset),
        .d    (echo),
        .q    (echo_s)
    );

    // Delayed copy of the synchronized echo for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_s_q_reg <= 1'b0;
        end else begin
            echo_s_q_reg <= echo_s;
        end
    end

    assign echo_rise   = echo_s & ~echo_s_q_reg;
    assign cnt_sat_inc = (cnt_reg == MAX_CNT) ? cnt_reg : cnt_reg + CNT_ONE;
    assign cnt_last    = ((cnt_reg + CNT_ONE) == MAX_CNT);

    // Per-tap qualification for the final selection, and flattening of the results.
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
        assign qualify[gi] = ~timeout_reg[gi] & (tap_lat_reg[gi] >= target_reg);
        assign tap_lat[gi*LAT_W +: LAT_W] = tap_lat_reg[gi];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath updates for the calibration sequence.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        target_next  = target_reg;
        tap_lat_next = tap_lat_reg;
        timeout_next = timeout_reg;
        mux_sel_next = mux_sel_reg;
        probe_next   = probe_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        fail_next    = fail_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    target_next = target;
                    for (int t = 0; t < NUM_TAPS; t++) begin
                        tap_lat_next[t] = '0;
                    end
                    timeout_next = '0;
                    fail_next    = 1'b0;
                    mux_sel_next = '0;
                    busy_next    = 1'b1;
                    state_next   = LAUNCH;
                end
            end

            LAUNCH: begin
                probe_next = 1'b1;
                cnt_next   = '0;
                state_next = WAIT;
            end

            WAIT: begin
                // When the rise is observed, echo_s went high on the previous
                // edge, which is exactly cnt_reg edges after probe went high.
                if (echo_rise) begin
                    tap_lat_next[mux_sel_reg] = cnt_reg;
                    probe_next = 1'b0;
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else if (cnt_last) begin
                    tap_lat_next[mux_sel_reg] = MAX_CNT;
                    timeout_next[mux_sel_reg] = 1'b1;
                    probe_next = 1'b0;
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt_sat_inc;
                end
            end

            DRAIN: begin
                // Let the echo settle low before moving the mux to another tap.
                if (!echo_s) begin
                    state_next = NEXT;
                end else if (cnt_last) begin
                    timeout_next[mux_sel_reg] = 1'b1;
                    state_next = NEXT;
                end else begin
                    cnt_next = cnt_sat_inc;
                end
            end

            NEXT: begin
                if (mux_sel_reg == LAST_TAP) begin
                    state_next = EVAL;
                end else begin
                    mux_sel_next = mux_sel_reg + TAP_W'(1);
                    state_next   = LAUNCH;
                end
            end

            EVAL: begin
                if (|qualify) begin
                    mux_sel_next = lowest_set(qualify);
                end else begin
                    mux_sel_next = LAST_TAP;
                    fail_next    = 1'b1;
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            target_reg  <= '0;
            for (int t = 0; t < NUM_TAPS; t++) begin
                tap_lat_reg[t] <= '0;
            end
            timeout_reg <= '0;
            mux_sel_reg <= '0;
            probe_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            target_reg  <= target_next;
            tap_lat_reg <= tap_lat_next;
            timeout_reg <= timeout_next;
            mux_sel_reg <= mux_sel_next;
            probe_reg   <= probe_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            fail_reg    <= fail_next;
        end
    end

    assign probe   = probe_reg;
    assign mux_sel = mux_sel_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign fail    = fail_reg;

endmodule

// File: tb/tb_delay_tap_calibrator.sv
// Self-checking bench for delay_tap_calibrator with a per-tap delay-line model.
module tb_delay_tap_calibrator;

    localparam int MAXW  = 255;
    localparam int BOUND = 6000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  target;
    logic        echo;
    logic        probe;
    logic [1:0]  mux_sel;
    logic        busy;
    logic        done;
    logic        fail;
    logic [31:0] tap_lat;

    // Tap behaviour: mode 0 = delay of dly cycles, 1 = echo stuck low, 2 = echo stuck high.
    int mode [4];
    int dly  [4];
    logic [255:0] line_q [4];

    int exp_lat [4];
    int exp_sel;
    int exp_fail;

    int n_cmp;
    int n_bad;
    int done_total;
    int done_base;
    logic [1:0]  cap_sel;
    logic        cap_fail;
    logic        cap_busy;
    logic [31:0] cap_lat;

    delay_tap_calibrator dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .target (target),
        .echo   (echo),
        .probe  (probe),
        .mux_sel(mux_sel),
        .busy   (busy),
        .done   (done),
        .fail   (fail),
        .tap_lat(tap_lat)
    );

    always #5 clk = ~clk;

    // One independent delay line per tap, each fed only while its tap is selected.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < 4; t++) line_q[t] <= '0;
        end else begin
            for (int t = 0; t < 4; t++) line_q[t] <= {line_q[t][254:0], probe & (mux_sel == 2'(t))};
        end
    end

    always_comb begin
        int d;
        d = dly[mux_sel];
        echo = 1'b0;
        if (mode[mux_sel] == 2) echo = 1'b1;
        else if (mode[mux_sel] == 0) echo = (d == 0) ? probe : line_q[mux_sel][d-1];
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_total++;
    end

    // Reference: latency = delay + 2 synchronizer edges; anything reaching MAX_WAIT times out.
    task automatic model(input int tgt);
        bit found;
        found = 0;
        exp_sel = 3;
        for (int t = 0; t < 4; t++) begin
            bit ok;
            ok = (mode[t] == 0) && (dly[t] + 2 < MAXW);
            exp_lat[t] = ok ? dly[t] + 2 : MAXW;
            if (ok && exp_lat[t] >= tgt && !found) begin
                found = 1;
                exp_sel = t;
            end
        end
        exp_fail = found ? 0 : 1;
    endtask

    task automatic set_taps(input int m0, input int d0, input int m1, input int d1,
                            input int m2, input int d2, input int m3, input int d3);
        mode[0] = m0; dly[0] = d0; mode[1] = m1; dly[1] = d1;
        mode[2] = m2; dly[2] = d2; mode[3] = m3; dly[3] = d3;
    endtask

    task automatic start_cal(input int tgt);
        @(negedge clk);
        done_base = done_total;
        start = 1'b1;
        target = 8'(tgt);
        @(negedge clk);
        start = 1'b0;
        target = 8'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                cap_sel = mux_sel; cap_fail = fail; cap_busy = busy; cap_lat = tap_lat;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (probe !== 1'b0) begin n_bad++; $display("FAIL reset_probe: got %b expected 0", probe); end
        n_cmp++; if (mux_sel !== 2'd0) begin n_bad++; $display("FAIL reset_mux_sel: got %0d expected 0", mux_sel); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b expected 0", fail); end
        n_cmp++; if (tap_lat !== 32'h0) begin n_bad++; $display("FAIL reset_tap_lat: got %h expected 0", tap_lat); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
        $display("test_reset: outputs checked in and after reset");
    endtask

    task automatic test_start_timing();
        bit ok;
        set_taps(0, 0, 0, 0, 0, 0, 0, 0);
        start_cal(2);
        n_cmp++; if (busy !== 1'b1 || probe !== 1'b0) begin n_bad++; $display("FAIL timing_launch: busy=%b probe=%b expected 1/0", busy, probe); end
        @(negedge clk);
        n_cmp++; if (probe !== 1'b1) begin n_bad++; $display("FAIL timing_probe: got %b expected 1", probe); end
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL timing_done: no done within %0d cycles", BOUND); end
        $display("test_start_timing: probe one edge after launch");
    endtask

    task automatic test_loopback();
        bit ok;
        set_taps(0, 0, 0, 0, 0, 0, 0, 0);
        model(2); start_cal(2); wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL loopback_done: no done within %0d cycles", BOUND); end
        for (int t = 0; t < 4; t++) begin
            n_cmp++; if (cap_lat[t*8 +: 8] !== 8'(exp_lat[t])) begin n_bad++; $display("FAIL loopback_lat%0d: got %0d expected %0d", t, cap_lat[t*8 +: 8], exp_lat[t]); end
        end
        n_cmp++; if (cap_sel !== 2'(exp_sel)) begin n_bad++; $display("FAIL loopback_sel: got %0d expected %0d", cap_sel, exp_sel); end
        n_cmp++; if (cap_fail !== 1'(exp_fail)) begin n_bad++; $display("FAIL loopback_fail: got %b expected %0d", cap_fail, exp_fail); end
        n_cmp++; if (cap_busy !== 1'b0) begin n_bad++; $display("FAIL loopback_busy: got %b expected 0", cap_busy); end
        n_cmp++; if (done_total - done_base !== 1) begin n_bad++; $display("FAIL loopback_done_count: got %0d expected 1", done_total - done_base); end
        $display("test_loopback: sel=%0d fail=%b lat=%h", cap_sel, cap_fail, cap_lat);
    endtask

    task automatic test_graded(input int tgt);
        bit ok;
        set_taps(0, 1, 0, 3, 0, 6, 0, 12);
        model(tgt); start_cal(tgt); wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL graded_done(t=%0d): no done within %0d cycles", tgt, BOUND); end
        for (int t = 0; t < 4; t++) begin
            n_cmp++; if (cap_lat[t*8 +: 8] !== 8'(exp_lat[t])) begin n_bad++; $display("FAIL graded_lat%0d(t=%0d): got %0d expected %0d", t, tgt, cap_lat[t*8 +: 8], exp_lat[t]); end
        end
        n_cmp++; if (cap_sel !== 2'(exp_sel)) begin n_bad++; $display("FAIL graded_sel(t=%0d): got %0d expected %0d", tgt, cap_sel, exp_sel); end
        n_cmp++; if (cap_fail !== 1'(exp_fail)) begin n_bad++; $display("FAIL graded_fail(t=%0d): got %b expected %0d", tgt, cap_fail, exp_fail); end
        n_cmp++; if (done_total - done_base !== 1) begin n_bad++; $display("FAIL graded_done_count(t=%0d): got %0d expected 1", tgt, done_total - done_base); end
        $display("test_graded target=%0d: sel=%0d fail=%b lat=%h", tgt, cap_sel, cap_fail, cap_lat);
    endtask

    task automatic test_stuck(input int stuck_high, input int d0, input int tgt);
        bit ok;
        if (stuck_high != 0) set_taps(2, 0, 2, 0, 2, 0, 2, 0);
        else set_taps(0, d0, 1, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        model(tgt); start_cal(tgt); wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stuck%0d_done: no done within %0d cycles", stuck_high, BOUND); end
        for (int t = 0; t < 4; t++) begin
            n_cmp++; if (cap_lat[t*8 +: 8] !== 8'(exp_lat[t])) begin n_bad++; $display("FAIL stuck%0d_lat%0d: got %0d expected %0d", stuck_high, t, cap_lat[t*8 +: 8], exp_lat[t]); end
        end
        n_cmp++; if (cap_sel !== 2'(exp_sel)) begin n_bad++; $display("FAIL stuck%0d_sel: got %0d expected %0d", stuck_high, cap_sel, exp_sel); end
        n_cmp++; if (cap_fail !== 1'(exp_fail)) begin n_bad++; $display("FAIL stuck%0d_fail: got %b expected %0d", stuck_high, cap_fail, exp_fail); end
        $display("test_stuck high=%0d d0=%0d target=%0d: sel=%0d fail=%b lat=%h", stuck_high, d0, tgt, cap_sel, cap_fail, cap_lat);
    endtask

    task automatic test_start_while_busy();
        bit ok;
        bit seen;
        set_taps(0, 1, 0, 3, 0, 6, 0, 12);
        model(7); start_cal(7);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (probe === 1'b1) seen = 1;
            else @(negedge clk);
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL busy_probe: probe never rose within 50 cycles"); end
        @(negedge clk); start = 1'b1; target = 8'd0;
        @(negedge clk); start = 1'b0;
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_done: no done within %0d cycles", BOUND); end
        n_cmp++; if (cap_sel !== 2'(exp_sel)) begin n_bad++; $display("FAIL busy_sel: got %0d expected %0d", cap_sel, exp_sel); end
        n_cmp++; if (cap_lat[0 +: 8] !== 8'(exp_lat[0])) begin n_bad++; $display("FAIL busy_lat0: got %0d expected %0d", cap_lat[0 +: 8], exp_lat[0]); end
        n_cmp++; if (done_total - done_base !== 1) begin n_bad++; $display("FAIL busy_done_count: got %0d expected 1", done_total - done_base); end
        $display("test_start_while_busy: sel=%0d dones=%0d", cap_sel, done_total - done_base);
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit hit;
        logic prev_probe;
        set_taps(0, 1, 0, 3, 0, 6, 0, 12);
        start_cal(7);
        hit = 0;
        prev_probe = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (mux_sel === 2'd2 && prev_probe === 1'b1 && probe === 1'b0) hit = 1;
            else begin prev_probe = probe; @(negedge clk); end
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL midreset_drain: tap 2 drain not reached"); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (probe !== 1'b0) begin n_bad++; $display("FAIL midreset_probe: got %b expected 0", probe); end
        n_cmp++; if (mux_sel !== 2'd0) begin n_bad++; $display("FAIL midreset_mux_sel: got %0d expected 0", mux_sel); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_cmp++; if (fail !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midreset_fail_done: got %b/%b expected 0/0", fail, done); end
        n_cmp++; if (tap_lat !== 32'h0) begin n_bad++; $display("FAIL midreset_tap_lat: got %h expected 0", tap_lat); end
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model(7); start_cal(7); wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midreset_recal_done: no done within %0d cycles", BOUND); end
        n_cmp++; if (cap_lat !== {8'(exp_lat[3]), 8'(exp_lat[2]), 8'(exp_lat[1]), 8'(exp_lat[0])}) begin n_bad++; $display("FAIL midreset_recal_lat: got %h", cap_lat); end
        n_cmp++; if (cap_sel !== 2'(exp_sel) || cap_fail !== 1'(exp_fail)) begin n_bad++; $display("FAIL midreset_recal_sel: got %0d/%b expected %0d/%0d", cap_sel, cap_fail, exp_sel, exp_fail); end
        $display("test_mid_reset: recalibration sel=%0d lat=%h", cap_sel, cap_lat);
    endtask

    task automatic test_random(input int iters);
        bit ok;
        int tgt;
        for (int it = 0; it < iters; it++) begin
            for (int t = 0; t < 4; t++) begin
                mode[t] = ($urandom_range(0, 7) == 0) ? 1 : 0;
                dly[t]  = $urandom_range(0, 30);
            end
            tgt = $urandom_range(0, 34);
            model(tgt); start_cal(tgt); wait_done(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_done: no done within %0d cycles", it, BOUND); end
            for (int t = 0; t < 4; t++) begin
                n_cmp++; if (cap_lat[t*8 +: 8] !== 8'(exp_lat[t])) begin n_bad++; $display("FAIL rand%0d_lat%0d: got %0d expected %0d", it, t, cap_lat[t*8 +: 8], exp_lat[t]); end
            end
            n_cmp++; if (cap_sel !== 2'(exp_sel)) begin n_bad++; $display("FAIL rand%0d_sel: got %0d expected %0d", it, cap_sel, exp_sel); end
            n_cmp++; if (cap_fail !== 1'(exp_fail)) begin n_bad++; $display("FAIL rand%0d_fail: got %b expected %0d", it, cap_fail, exp_fail); end
            n_cmp++; if (done_total - done_base !== 1) begin n_bad++; $display("FAIL rand%0d_done_count: got %0d expected 1", it, done_total - done_base); end
            $display("rand %0d: target=%0d sel=%0d fail=%b lat=%h", it, tgt, cap_sel, cap_fail, cap_lat);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        target = 8'd0;
        n_cmp = 0;
        n_bad = 0;
        done_total = 0;
        done_base = 0;
        set_taps(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        test_reset();
        test_start_timing();
        test_loopback();
        test_graded(7);
        test_graded(8);
        test_graded(20);
        test_stuck(0, 0, 0);
        test_stuck(0, 4, 5);
        test_stuck(1, 0, 0);
        test_stuck(0, 252, 254);
        test_start_while_busy();
        test_mid_reset();
        test_random(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
